// File: rtl/direct_ramp_bank.sv
// Bank of CH_NUM DDS control words with shadow/active registers, a global commit
// and optional per-channel linear ramping toward the committed target.
module direct_ramp_bank #(
  parameter int CH_NUM     = 3,
  parameter int WORD_WIDTH = 32,
  parameter int TICK_DIV   = 120,
  parameter int ADDR_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         param_wen,
  input  logic                         step_wen,
  input  logic [ADDR_W-1:0]            param_addr,
  input  logic [WORD_WIDTH-1:0]        param_word,
  input  logic [CH_NUM-1:0]            mode,
  input  logic [CH_NUM-1:0]            direct_en,
  input  logic                         commit,
  output logic [CH_NUM*WORD_WIDTH-1:0] direct_output,
  output logic [CH_NUM-1:0]            busy,
  output logic                         commit_ack
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [WORD_WIDTH-1:0] shadow_q [CH_NUM];
  logic [WORD_WIDTH-1:0] step_q   [CH_NUM];
  logic [WORD_WIDTH-1:0] target_q [CH_NUM];
  logic [WORD_WIDTH-1:0] out_q    [CH_NUM];
  logic [CH_NUM-1:0]     mode_q;
  logic [CH_NUM-1:0]     busy_q;
  logic [CNT_W-1:0]      tick_cnt;
  logic                  tick;

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // Handshake: commit is a one-cycle strobe with no backpressure; commit_ack
  // is high for exactly the cycle after every cycle in which commit was high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) commit_ack <= 1'b0;
    else       commit_ack <= commit;
  end

  // Registers are read before being written, so a commit sees the old shadow
  // and a ramp tick uses the old step when a write lands on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < CH_NUM; k++) begin
        shadow_q[k] <= '0;
        step_q[k]   <= '0;
        target_q[k] <= '0;
        out_q[k]    <= '0;
      end
      mode_q <= '0;
      busy_q <= '0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (commit && direct_en[k]) begin
          target_q[k] <= shadow_q[k];
          mode_q[k]   <= mode[k];
          if (!mode[k] || step_q[k] == '0) begin
            out_q[k]  <= shadow_q[k];
            busy_q[k] <= 1'b0;
          end else begin
            busy_q[k] <= 1'b1;
          end
        end else if (busy_q[k] && mode_q[k] && tick) begin
          if (out_q[k] < target_q[k] && (target_q[k] - out_q[k]) > step_q[k]) begin
            out_q[k] <= out_q[k] + step_q[k];
          end else if (out_q[k] > target_q[k] && (out_q[k] - target_q[k]) > step_q[k]) begin
            out_q[k] <= out_q[k] - step_q[k];
          end else begin
            out_q[k]  <= target_q[k];
            busy_q[k] <= 1'b0;
          end
        end
        // Addresses at or above CH_NUM match no channel and are dropped.
        if (param_wen && param_addr == ADDR_W'(k)) shadow_q[k] <= param_word;
        if (step_wen && param_addr == ADDR_W'(k))  step_q[k]   <= param_word;
      end
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_out
    assign direct_output[g*WORD_WIDTH +: WORD_WIDTH] = out_q[g];
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_direct_ramp_bank.sv
// Randomized and directed bench for direct_ramp_bank against a cycle-level
// arithmetic reference model of the control-word bank.
module tb_direct_ramp_bank;
  localparam int CH = 3;
  localparam int W  = 32;
  localparam int TD = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          param_wen = 1'b0;
  logic          step_wen = 1'b0;
  logic [AW-1:0] param_addr = '0;
  logic [W-1:0]  param_word = '0;
  logic [CH-1:0] mode = '0;
  logic [CH-1:0] direct_en = '0;
  logic          commit = 1'b0;
  logic [CH*W-1:0] direct_output;
  logic [CH-1:0] busy;
  logic          commit_ack;

  direct_ramp_bank #(.CH_NUM(CH), .WORD_WIDTH(W), .TICK_DIV(TD)) dut (
    .clk(clk), .rstn(rstn), .param_wen(param_wen), .step_wen(step_wen),
    .param_addr(param_addr), .param_word(param_word), .mode(mode),
    .direct_en(direct_en), .commit(commit), .direct_output(direct_output),
    .busy(busy), .commit_ack(commit_ack)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  logic [W-1:0]  m_sh [CH];
  logic [W-1:0]  m_st [CH];
  logic [W-1:0]  m_tg [CH];
  logic [W-1:0]  m_out[CH];
  logic [CH-1:0] m_busy;
  logic          m_ack;
  int            m_cycle;
  logic [W-1:0]  exp_q[$];

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_sh[k] = '0; m_st[k] = '0; m_tg[k] = '0; m_out[k] = '0;
    end
    m_busy = '0; m_ack = 1'b0; m_cycle = 0;
    exp_q.delete();
  endtask

  // One clock edge of the specified behaviour, using the inputs currently driven.
  task automatic model_edge();
    bit is_tick;
    is_tick = ((m_cycle % TD) == TD - 1);
    for (int k = 0; k < CH; k++) begin
      if (commit && direct_en[k]) begin
        m_tg[k] = m_sh[k];
        if (!mode[k] || m_st[k] == 0) begin
          m_out[k] = m_sh[k]; m_busy[k] = 1'b0;
        end else m_busy[k] = 1'b1;
      end else if (m_busy[k] && is_tick) begin
        longint d;
        d = longint'(m_tg[k]) - longint'(m_out[k]);
        if (d > longint'(m_st[k]))        m_out[k] = m_out[k] + m_st[k];
        else if (-d > longint'(m_st[k]))  m_out[k] = m_out[k] - m_st[k];
        else begin m_out[k] = m_tg[k]; m_busy[k] = 1'b0; end
      end
    end
    if (int'(param_addr) < CH) begin
      if (param_wen) m_sh[param_addr] = param_word;
      if (step_wen)  m_st[param_addr] = param_word;
    end
    m_ack = commit;
    m_cycle++;
  endtask

  // scoreboard: expected outputs queued per edge, compared after the edge
  task automatic run_cycle();
    model_edge();
    for (int k = 0; k < CH; k++) exp_q.push_back(m_out[k]);
    exp_q.push_back(W'(m_busy));
    exp_q.push_back(W'(m_ack));
    @(posedge clk); #1;
    for (int k = 0; k < CH; k++)
      check($sformatf("out%0d@%0d", k, m_cycle), direct_output[k*W +: W], exp_q.pop_front());
    check($sformatf("busy@%0d", m_cycle), W'(busy), exp_q.pop_front());
    check($sformatf("ack@%0d", m_cycle), W'(commit_ack), exp_q.pop_front());
  endtask

  // driver tasks
  task automatic drv(input bit pw, input bit sw, input int addr, input logic [W-1:0] word,
                     input bit cm, input logic [CH-1:0] den, input logic [CH-1:0] md);
    param_wen = pw; step_wen = sw; param_addr = AW'(addr); param_word = word;
    commit = cm; direct_en = den; mode = md;
    run_cycle();
    param_wen = 1'b0; step_wen = 1'b0; commit = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [W-1:0] word);
    drv(1, 0, addr, word, 0, '0, '0);
  endtask

  task automatic wr_step(input int addr, input logic [W-1:0] word);
    drv(0, 1, addr, word, 0, '0, '0);
  endtask

  task automatic do_commit(input logic [CH-1:0] den, input logic [CH-1:0] md);
    drv(0, 0, 0, '0, 1, den, md);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic check_reset_now(input string tag);
    for (int k = 0; k < CH; k++) check($sformatf("%s_out%0d", tag, k), direct_output[k*W +: W], '0);
    check({tag, "_busy"}, W'(busy), '0);
    check({tag, "_ack"}, W'(commit_ack), '0);
  endtask

  initial begin
    // 1: reset and a plain jump on channel 0
    model_reset();
    #12;
    check_reset_now("rst");
    @(negedge clk); rstn = 1'b1;
    wr(0, 32'h1000);
    do_commit(3'b001, 3'b000);
    check("t1_ch0", direct_output[0 +: W], 32'h1000);
    check("t1_ch1", direct_output[W +: W], 32'h0);
    idle(1);

    // 2: upward ramp on channel 2
    wr(2, 100);
    do_commit(3'b100, 3'b000);
    wr_step(2, 30);
    wr(2, 200);
    do_commit(3'b100, 3'b100);
    check("t2_busy", W'(busy[2]), 1);
    idle(18);
    check("t2_final", direct_output[2*W +: W], 200);

    // 3: downward ramp without underflow, upward without overflow
    wr(0, 200);
    do_commit(3'b001, 3'b000);
    wr(0, 0);
    wr_step(0, 70);
    do_commit(3'b001, 3'b001);
    idle(14);
    check("t3_down", direct_output[0 +: W], 0);
    wr(1, 32'hFFFF_FFF0);
    do_commit(3'b010, 3'b000);
    wr(1, 32'hFFFF_FFFF);
    wr_step(1, 32'h100);
    do_commit(3'b010, 3'b010);
    idle(6);
    check("t3_up", direct_output[W +: W], 32'hFFFF_FFFF);
    check("t3_busy", W'(busy), 0);

    // 4: write and commit in the same cycle
    wr(1, 32'h22);
    drv(1, 0, 1, 32'h55, 1, 3'b010, 3'b000);
    check("t4_old", direct_output[W +: W], 32'h22);
    do_commit(3'b010, 3'b000);
    check("t4_new", direct_output[W +: W], 32'h55);

    // 5: jump aborts a ramp; out-of-range address is ignored
    wr(0, 1000);
    wr_step(0, 5);
    do_commit(3'b001, 3'b001);
    idle(10);
    wr(0, 32'h10);
    do_commit(3'b001, 3'b000);
    check("t5_abort", direct_output[0 +: W], 32'h10);
    check("t5_busy", W'(busy[0]), 0);
    drv(1, 1, 3, 32'hDEAD, 0, '0, '0);
    do_commit(3'b111, 3'b000);
    idle(2);

    // 6: asynchronous reset mid-ramp
    wr(2, 5000);
    wr_step(2, 7);
    do_commit(3'b100, 3'b100);
    idle(5);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check_reset_now("arst");
    model_reset();
    @(negedge clk); rstn = 1'b1;
    do_commit(3'b111, 3'b111);
    idle(6);
    check("t6_ch2", direct_output[2*W +: W], 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit pw, sw, cm;
      logic [W-1:0] word;
      pw = ($urandom_range(0, 5) == 0);
      sw = ($urandom_range(0, 7) == 0);
      cm = ($urandom_range(0, 9) == 0);
      if (sw && !pw)
        word = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 400));
      else
        word = ($urandom_range(0, 5) == 0) ? W'($urandom) : W'($urandom_range(0, 3000));
      drv(pw, sw, $urandom_range(0, 3), word, cm, CH'($urandom), CH'($urandom));
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
